imm_pack: RTL and testbench

IMM_PACK -- requirements
Module: imm_pack

---
 rtl/imm_pack.sv | 148 ++++++++++++++
 tb/tb_imm_pack.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/imm_pack.sv
// imm_pack: two-stage pipeline that inserts an immediate into a RISC-V instruction word.
// Optional macro IMM_RANGE_CHECK_EN enables range checking (out_err) and the saturating err_count.
module imm_pack #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_type,
    input  logic [31:0]      in_base,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_err,
    input  logic             err_clr,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    logic        s1_valid_q, s1_valid_d;
    logic [2:0]  s1_type_q;
    logic [31:0] s1_base_q;
    logic [31:0] s1_imm_q;
    logic        s2_valid_q, s2_valid_d;
    logic [31:0] s2_instr_q;
    logic [31:0] pack_instr;
    logic        in_fire;
    logic        s2_load;

    // Stage 2 frees up when empty or delivering; stage 1 likewise relative to stage 2.
    assign s2_load    = s1_valid_q && (!s2_valid_q || out_ready);
    assign in_ready   = !(s1_valid_q && s2_valid_q && !out_ready);
    assign in_fire    = in_valid && in_ready;
    assign s1_valid_d = in_fire || (s1_valid_q && !s2_load);
    assign s2_valid_d = s2_load || (s2_valid_q && !out_ready);

    always_comb begin
        pack_instr = s1_base_q;
        case (s1_type_q)
            FMT_I: pack_instr[31:20] = s1_imm_q[11:0];
            FMT_S: begin
                pack_instr[31:25] = s1_imm_q[11:5];
                pack_instr[11:7]  = s1_imm_q[4:0];
            end
            FMT_B: begin
                pack_instr[31]    = s1_imm_q[12];
                pack_instr[30:25] = s1_imm_q[10:5];
                pack_instr[11:8]  = s1_imm_q[4:1];
                pack_instr[7]     = s1_imm_q[11];
            end
            FMT_U: pack_instr[31:12] = s1_imm_q[31:12];
            FMT_J: begin
                pack_instr[31]    = s1_imm_q[20];
                pack_instr[30:21] = s1_imm_q[10:1];
                pack_instr[20]    = s1_imm_q[11];
                pack_instr[19:12] = s1_imm_q[19:12];
            end
            default: pack_instr = s1_base_q;
        endcase
    end

    // NOTE: every register here uses non-blocking assignment so all stages update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: datapath registers are reset too, so out_instr reads zero immediately after reset.
            s1_valid_q <= 1'b0;
            s1_type_q  <= 3'd0;
            s1_base_q  <= 32'd0;
            s1_imm_q   <= 32'd0;
            s2_valid_q <= 1'b0;
            s2_instr_q <= 32'd0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            if (in_fire) begin
                s1_type_q <= in_type;
                s1_base_q <= in_base;
                s1_imm_q  <= in_imm;
            end
            if (s2_load) begin
                s2_instr_q <= pack_instr;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign out_instr = s2_instr_q;

`ifdef IMM_RANGE_CHECK_EN
    logic             pack_err;
    logic             s2_err_q;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        pack_err = 1'b0;
        case (s1_type_q)
            FMT_R:        pack_err = |s1_imm_q;
            FMT_I, FMT_S: pack_err = s1_imm_q[31:11] != {21{s1_imm_q[11]}};
            FMT_B:        pack_err = (s1_imm_q[31:12] != {20{s1_imm_q[12]}}) || s1_imm_q[0];
            FMT_U:        pack_err = |s1_imm_q[11:0];
            FMT_J:        pack_err = (s1_imm_q[31:20] != {12{s1_imm_q[20]}}) || s1_imm_q[0];
            default:      pack_err = 1'b1;
        endcase
    end

    // Clear wins over a coincident error handshake; the count sticks at all-ones.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = '0;
        end else if (s2_valid_q && out_ready && s2_err_q && !(&err_cnt_q)) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_err_q  <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
            if (s2_load) begin
                s2_err_q <= pack_err;
            end
        end
    end

    assign out_err   = s2_err_q;
    assign err_count = err_cnt_q;
`else
    logic unused_err_clr;

    assign unused_err_clr = err_clr;
    assign out_err        = 1'b0;
    assign err_count      = '0;
`endif

endmodule

// File: tb/tb_imm_pack.sv
// Directed self-checking bench for imm_pack (CNT_W=2 so saturation is reachable quickly).
module tb_imm_pack;

`ifdef IMM_RANGE_CHECK_EN
    localparam logic RC = 1'b1;
`else
    localparam logic RC = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_type;
    logic [31:0] in_base;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;
    logic        err_clr;
    logic [1:0]  err_count;

    int n_cmp = 0;
    int n_err = 0;

    imm_pack #(.CNT_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_type   (in_type),
        .in_base   (in_base),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err),
        .err_clr   (err_clr),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request through an empty pipeline with out_ready=1.
    task automatic xfer(input string tag, input logic [2:0] t, input logic [31:0] b,
                        input logic [31:0] imm, input logic [31:0] exp_instr,
                        input logic exp_e, input logic [1:0] cnt_after, input logic clr);
        check({tag, "_rdy"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_type  = t;
        in_base  = b;
        in_imm   = imm;
        tick();
        in_valid = 1'b0;
        in_base  = 32'hDEADBEEF;
        in_imm   = 32'hA5A5A5A5;
        check({tag, "_lat1"}, 32'(out_valid), 32'd0);
        tick();
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_instr"}, out_instr, exp_instr);
        check({tag, "_err"}, 32'(out_err), 32'(RC & exp_e));
        err_clr = clr;
        tick();
        err_clr = 1'b0;
        check({tag, "_drain"}, 32'(out_valid), 32'd0);
        check({tag, "_cnt"}, 32'(err_count), RC ? 32'(cnt_after) : 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_type   = 3'd0;
        in_base   = 32'd0;
        in_imm    = 32'd0;
        out_ready = 1'b1;
        err_clr   = 1'b0;
        #12;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_instr", out_instr, 32'd0);
        check("rst_err", 32'(out_err), 32'd0);
        check("rst_cnt", 32'(err_count), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        #8 rst_n = 1'b1;
        tick();

        // Legal immediates of every format.
        xfer("i_type",  3'd1, 32'h00000513, 32'h0000007F, 32'h07F00513, 1'b0, 2'd0, 1'b0);
        xfer("b_type",  3'd3, 32'h00000063, 32'hFFFFFFFC, 32'hFE000EE3, 1'b0, 2'd0, 1'b0);
        xfer("j_type",  3'd5, 32'h0000006F, 32'h00000008, 32'h0080006F, 1'b0, 2'd0, 1'b0);
        xfer("s_type",  3'd2, 32'h00002023, 32'hFFFFFFF8, 32'hFE002C23, 1'b0, 2'd0, 1'b0);
        xfer("u_type",  3'd4, 32'h00000537, 32'h12345000, 32'h12345537, 1'b0, 2'd0, 1'b0);
        xfer("i_ovwr",  3'd1, 32'hFFF00513, 32'h00000001, 32'h00100513, 1'b0, 2'd0, 1'b0);
        xfer("r_type",  3'd0, 32'h00B50533, 32'h00000000, 32'h00B50533, 1'b0, 2'd0, 1'b0);

        // Erroneous immediates: truncated value still packed, counter saturates at 3.
        xfer("i_range", 3'd1, 32'h00000513, 32'h00000800, 32'h80000513, 1'b1, 2'd1, 1'b0);
        xfer("bad_typ", 3'd7, 32'h12345678, 32'h00000000, 32'h12345678, 1'b1, 2'd2, 1'b0);
        xfer("u_low",   3'd4, 32'h00000037, 32'h00000001, 32'h00000037, 1'b1, 2'd3, 1'b0);
        xfer("b_odd",   3'd3, 32'h00000063, 32'h00000005, 32'h00000263, 1'b1, 2'd3, 1'b0);
        xfer("j_range", 3'd5, 32'h0000006F, 32'h00100000, 32'h8000006F, 1'b1, 2'd3, 1'b0);
        xfer("clr_win", 3'd0, 32'h00000033, 32'h00000001, 32'h00000033, 1'b1, 2'd0, 1'b1);

        // Backpressure: two accepted, third stalls, outputs frozen, then in-order drain.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_type   = 3'd1;
        in_base   = 32'h00000513;
        in_imm    = 32'h00000001;
        tick();
        check("bp_rdy1", 32'(in_ready), 32'd1);
        in_imm = 32'h00000002;
        tick();
        check("bp_valid", 32'(out_valid), 32'd1);
        check("bp_full", 32'(in_ready), 32'd0);
        check("bp_a0", out_instr, 32'h00100513);
        in_imm = 32'h00000003;
        tick();
        check("bp_stall", 32'(in_ready), 32'd0);
        check("bp_a1", out_instr, 32'h00100513);
        tick();
        check("bp_hold_v", 32'(out_valid), 32'd1);
        check("bp_a2", out_instr, 32'h00100513);
        out_ready = 1'b1;
        #1;
        check("bp_rdy2", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("bp_b_v", 32'(out_valid), 32'd1);
        check("bp_b", out_instr, 32'h00200513);
        tick();
        check("bp_c_v", 32'(out_valid), 32'd1);
        check("bp_c", out_instr, 32'h00300513);
        tick();
        check("bp_empty", 32'(out_valid), 32'd0);

        // Reset with two requests in flight.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_imm    = 32'h00000004;
        tick();
        in_imm = 32'h00000005;
        tick();
        in_valid = 1'b0;
        check("mid_full", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_valid", 32'(out_valid), 32'd0);
        check("mid_instr", out_instr, 32'd0);
        check("mid_err", 32'(out_err), 32'd0);
        check("mid_ready", 32'(in_ready), 32'd1);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_idle", 32'(out_valid), 32'd0);
        end
        xfer("post_rst", 3'd1, 32'h00000513, 32'h00000006, 32'h00600513, 1'b0, 2'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
